// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared types and defaults for the on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;

  // Arbitration state: free arbitration, or the grant pinned to one master.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  // Identifies one of the two requesters (0 = Nios data port, 1 = search engine).
  typedef logic master_id_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM-style requester bus shared by the Nios data port and the search engine.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = onchip_mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = onchip_mem_arb_pkg::DEF_DATA_W
);

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                lock;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Combinational two-way pick: lone requester wins, ties go to the master
// that did not win last (or always to master 0 in fixed-priority mode).
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  // One-hot grant from the current request pattern.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (fixed_prio) begin
          grant = 2'b01;
        end else if (last_grant == 1'b0) begin
          grant = 2'b10;
        end else begin
          grant = 2'b01;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between two requesters, one access per
// cycle, with an optional bounded lock for read-modify-write sequences.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIXED_PRIO = 0,
  parameter int LOCK_MAX   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam logic [7:0] LAST_CNT = 8'(LOCK_MAX - 1);

  logic [1:0] req_s;
  logic [1:0] lock_req_s;
  logic [1:0] arb_grant_s;
  logic [1:0] grant_s;
  master_id_t gid_s;
  master_id_t own_s;
  logic       acc_s;
  logic       acc_wr_s;
  logic       acc_lock_s;
  logic       acc_rd_s;

  arb_state_e state_r, state_nx_s;
  master_id_t last_grant_r, last_grant_nx_s;
  logic [7:0] lock_cnt_r, lock_cnt_nx_s;
  logic [1:0] rdv_r;
  logic       clken_r;

  assign req_s      = {m1.read | m1.write, m0.read | m0.write};
  assign lock_req_s = {m1.lock, m0.lock};
  assign own_s      = (state_r == LOCK1);

  rr_arb2 u_rr_arb2 (
    .req        (req_s),
    .last_grant (last_grant_r),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (arb_grant_s)
  );

  // Final grant: free pick in ARB, only the lock owner while locked, nothing in reset.
  always_comb begin
    grant_s = 2'b00;
    if (!reset_n) begin
      grant_s = 2'b00;
    end else begin
      case (state_r)
        ARB:     grant_s = arb_grant_s;
        LOCK0:   grant_s = {1'b0, req_s[0]};
        LOCK1:   grant_s = {req_s[1], 1'b0};
        default: grant_s = 2'b00;
      endcase
    end
  end

  assign m0.waitrequest = ~grant_s[0];
  assign m1.waitrequest = ~grant_s[1];
  assign gid_s          = grant_s[1];
  assign acc_s          = |grant_s;
  // A simultaneous read and write is served as a write, so no data comes back.
  assign acc_rd_s       = acc_s & ~acc_wr_s;

  // RAM drive: combinational mux of the granted master.
  always_comb begin
    ram_address    = m0.address;
    ram_byteenable = m0.byteenable;
    ram_writedata  = m0.writedata;
    acc_wr_s       = m0.write;
    acc_lock_s     = m0.lock;
    if (gid_s) begin
      ram_address    = m1.address;
      ram_byteenable = m1.byteenable;
      ram_writedata  = m1.writedata;
      acc_wr_s       = m1.write;
      acc_lock_s     = m1.lock;
    end else begin
      ram_address    = m0.address;
      ram_byteenable = m0.byteenable;
      ram_writedata  = m0.writedata;
      acc_wr_s       = m0.write;
      acc_lock_s     = m0.lock;
    end
    ram_chipselect = acc_s;
    ram_write      = acc_s & acc_wr_s;
  end

  // Next-state logic for lock entry, lock exit and the round-robin pointer.
  always_comb begin
    state_nx_s      = state_r;
    lock_cnt_nx_s   = lock_cnt_r;
    last_grant_nx_s = last_grant_r;
    if (acc_s) begin
      last_grant_nx_s = gid_s;
    end else begin
      last_grant_nx_s = last_grant_r;
    end
    case (state_r)
      ARB: begin
        if (acc_s && acc_lock_s) begin
          state_nx_s    = gid_s ? LOCK1 : LOCK0;
          lock_cnt_nx_s = 8'd0;
        end else begin
          state_nx_s = ARB;
        end
      end
      LOCK0, LOCK1: begin
        lock_cnt_nx_s = lock_cnt_r + 8'd1;
        if (lock_cnt_r == LAST_CNT) begin
          // Forced release: the other master wins the next tie.
          state_nx_s      = ARB;
          last_grant_nx_s = own_s;
          lock_cnt_nx_s   = 8'd0;
        end else if (acc_s && !acc_lock_s) begin
          state_nx_s    = ARB;
          lock_cnt_nx_s = 8'd0;
        end else if (!req_s[own_s] && !lock_req_s[own_s]) begin
          state_nx_s    = ARB;
          lock_cnt_nx_s = 8'd0;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s    = ARB;
        lock_cnt_nx_s = 8'd0;
      end
    endcase
  end

  // Arbitration state registers; master 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ARB;
      last_grant_r <= 1'b1;
      lock_cnt_r   <= 8'd0;
    end else begin
      state_r      <= state_nx_s;
      last_grant_r <= last_grant_nx_s;
      lock_cnt_r   <= lock_cnt_nx_s;
    end
  end

  // Read-return routing: flag the issuing master one cycle after its read is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv_r <= 2'b00;
    end else begin
      rdv_r <= {acc_rd_s & gid_s, acc_rd_s & ~gid_s};
    end
  end

  // RAM clock enable is held off in reset and on afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clken_r <= 1'b0;
    end else begin
      clken_r <= 1'b1;
    end
  end

  assign ram_clken        = clken_r;
  assign m0.readdatavalid = rdv_r[0];
  assign m1.readdatavalid = rdv_r[1];
  assign m0.readdata      = ram_readdata;
  assign m1.readdata      = ram_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter: table of per-cycle vectors plus
// hand-written lock, fixed-priority and reset sequences.
module tb_onchip_mem_arbiter;
  import onchip_mem_arb_pkg::*;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] X5 = 32'hA5A5_0005;
  localparam logic [31:0] X6 = 32'hA5A5_0006;
  localparam int NV = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) f0_if ();
  onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) f1_if ();

  logic [AW-1:0] ram_address, f_ram_address;
  logic [3:0]    ram_byteenable, f_ram_byteenable;
  logic          ram_chipselect, ram_write, ram_clken;
  logic          f_ram_chipselect, f_ram_write, f_ram_clken;
  logic [31:0]   ram_writedata, f_ram_writedata, ram_readdata;
  logic [31:0]   f_ram_readdata;
  assign f_ram_readdata = 32'h0;

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .LOCK_MAX(16)) dut (
    .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .LOCK_MAX(16)) dut_fp (
    .clk(clk), .reset_n(reset_n), .m0(f0_if), .m1(f1_if),
    .ram_address(f_ram_address), .ram_byteenable(f_ram_byteenable),
    .ram_chipselect(f_ram_chipselect), .ram_write(f_ram_write),
    .ram_writedata(f_ram_writedata), .ram_clken(f_ram_clken),
    .ram_readdata(f_ram_readdata)
  );

  // Behavioural 2048x32 RAM with byte lanes and one cycle of read latency.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  typedef struct packed {
    logic r0, w0, k0; logic [10:0] a0; logic [31:0] wd0; logic [3:0] be0;
    logic r1, w1, k1; logic [10:0] a1; logic [31:0] wd1; logic [3:0] be1;
    logic ew0, ew1, ev0, ev1; logic [31:0] erd;
  } vec_t;

  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic r0, w0, k0, input logic [10:0] a0, input logic [31:0] wd0, input logic [3:0] be0,
    input logic r1, w1, k1, input logic [10:0] a1, input logic [31:0] wd1, input logic [3:0] be1,
    input logic ew0, ew1, ev0, ev1, input logic [31:0] erd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.k0 = k0; v.a0 = a0; v.wd0 = wd0; v.be0 = be0;
    v.r1 = r1; v.w1 = w1; v.k1 = k1; v.a1 = a1; v.wd1 = wd1; v.be1 = be1;
    v.ew0 = ew0; v.ew1 = ew1; v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    m0_if.read = v.r0; m0_if.write = v.w0; m0_if.lock = v.k0; m0_if.address = v.a0;
    m0_if.writedata = v.wd0; m0_if.byteenable = v.be0;
    m1_if.read = v.r1; m1_if.write = v.w1; m1_if.lock = v.k1; m1_if.address = v.a1;
    m1_if.writedata = v.wd1; m1_if.byteenable = v.be1;
  endtask

  task automatic set_m(input logic r0, k0, r1, k1);
    m0_if.read = r0; m0_if.write = L; m0_if.lock = k0; m0_if.address = 11'd5;
    m1_if.read = r1; m1_if.write = L; m1_if.lock = k1; m1_if.address = 11'd6;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wait0"}, m0_if.waitrequest, 1);
    check({tag, " wait1"}, m1_if.waitrequest, 1);
    check({tag, " rdv0"}, m0_if.readdatavalid, 0);
    check({tag, " rdv1"}, m1_if.readdatavalid, 0);
    check({tag, " cs"}, ram_chipselect, 0);
    check({tag, " ram_write"}, ram_write, 0);
    check({tag, " clken"}, ram_clken, 0);
  endtask

  initial begin
    int first_m0, locked_acc, both, f0_acc, f1_acc;
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA5A5_0000 | i;
    mem[2047] = 32'h1234_5678;
    apply(mk(L,L,L,11'd0,32'h0,4'h0, L,L,L,11'd0,32'h0,4'h0, H,H,L,L,32'h0));
    f0_if.read = L; f0_if.write = L; f0_if.lock = L; f0_if.address = 11'd1;
    f0_if.writedata = 32'h0; f0_if.byteenable = 4'hF;
    f1_if.read = L; f1_if.write = L; f1_if.lock = L; f1_if.address = 11'd2;
    f1_if.writedata = 32'h0; f1_if.byteenable = 4'hF;

    //      r0 w0 k0 a0      wd0            be0   r1 w1 k1 a1       wd1            be1   ew0 ew1 ev0 ev1 erd
    vecs[0]  = mk(H,L,L,11'd5,32'h0,4'hF,         H,L,L,11'd6,32'h0,4'hF,         L,H,L,L,32'h0);
    vecs[1]  = mk(H,L,L,11'd5,32'h0,4'hF,         H,L,L,11'd6,32'h0,4'hF,         H,L,H,L,X5);
    vecs[2]  = mk(H,L,L,11'd5,32'h0,4'hF,         H,L,L,11'd6,32'h0,4'hF,         L,H,L,H,X6);
    vecs[3]  = mk(H,L,L,11'd5,32'h0,4'hF,         H,L,L,11'd6,32'h0,4'hF,         H,L,H,L,X5);
    vecs[4]  = mk(L,L,L,11'd0,32'h0,4'h0,         L,H,L,11'h7FF,32'hDEADBEEF,4'h3, H,L,L,H,X6);
    vecs[5]  = mk(L,L,L,11'd0,32'h0,4'h0,         H,L,L,11'h7FF,32'h0,4'hF,       H,L,L,L,32'h0);
    vecs[6]  = mk(L,L,L,11'd0,32'h0,4'h0,         L,L,L,11'd0,32'h0,4'h0,         H,H,L,H,32'h1234BEEF);
    vecs[7]  = mk(H,L,H,11'd5,32'h0,4'hF,         H,L,L,11'd6,32'h0,4'hF,         L,H,L,L,32'h0);
    vecs[8]  = mk(H,L,H,11'd5,32'h0,4'hF,         H,L,L,11'd6,32'h0,4'hF,         L,H,H,L,X5);
    vecs[9]  = mk(H,L,H,11'd5,32'h0,4'hF,         H,L,L,11'd6,32'h0,4'hF,         L,H,H,L,X5);
    vecs[10] = mk(H,L,L,11'd5,32'h0,4'hF,         H,L,L,11'd6,32'h0,4'hF,         L,H,H,L,X5);
    vecs[11] = mk(H,L,L,11'd5,32'h0,4'hF,         H,L,L,11'd6,32'h0,4'hF,         H,L,H,L,X5);
    vecs[12] = mk(L,L,L,11'd0,32'h0,4'h0,         L,L,L,11'd0,32'h0,4'h0,         H,H,L,H,X6);
    vecs[13] = mk(H,H,L,11'd9,32'hCAFEF00D,4'hF,  L,L,L,11'd0,32'h0,4'h0,         L,H,L,L,32'h0);
    vecs[14] = mk(H,L,L,11'd9,32'h0,4'hF,         L,L,L,11'd0,32'h0,4'h0,         L,H,L,L,32'h0);
    vecs[15] = mk(L,L,L,11'd0,32'h0,4'h0,         L,L,L,11'd0,32'h0,4'h0,         H,H,H,L,32'hCAFEF00D);

    // Reset: a write request is present but must not reach the RAM.
    m0_if.write = H; m0_if.address = 11'd3; m0_if.writedata = 32'hFFFF_FFFF; m0_if.byteenable = 4'hF;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    apply(mk(L,L,L,11'd0,32'h0,4'h0, L,L,L,11'd0,32'h0,4'h0, H,H,L,L,32'h0));
    check("no write in reset", mem[3], 32'hA5A5_0003);

    // Table: tie alternation, write-then-read, lock held, illegal read&write.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d wait0", i), m0_if.waitrequest, vecs[i].ew0);
      check($sformatf("v%0d wait1", i), m1_if.waitrequest, vecs[i].ew1);
      check($sformatf("v%0d rdv0", i), m0_if.readdatavalid, vecs[i].ev0);
      check($sformatf("v%0d rdv1", i), m1_if.readdatavalid, vecs[i].ev1);
      if (vecs[i].ev0)
        check($sformatf("v%0d rdata0", i), m0_if.readdata, vecs[i].erd);
      else if (vecs[i].ev1)
        check($sformatf("v%0d rdata1", i), m1_if.readdata, vecs[i].erd);
    end
    check("clken after reset", ram_clken, 1);

    // Forced release: m1 takes the lock alone, then both request with m1 locked.
    @(posedge clk); #1;
    set_m(L, L, H, H);
    @(negedge clk);
    check("lock take m1 accept", m1_if.waitrequest, 0);
    first_m0 = -1; locked_acc = 0; both = 0;
    for (int c = 1; c < 40; c++) begin
      @(posedge clk); #1;
      set_m(H, L, H, H);
      @(negedge clk);
      if (!m0_if.waitrequest && !m1_if.waitrequest) both++;
      if (first_m0 < 0 && !m1_if.waitrequest) locked_acc++;
      if (first_m0 < 0 && !m0_if.waitrequest) first_m0 = c;
    end
    check("forced locked accepts", locked_acc, 16);
    check("forced m0 first grant", first_m0, 17);
    check("forced no double accept", both, 0);
    @(posedge clk); #1;
    set_m(L, L, L, L);
    repeat (3) @(posedge clk);

    // Fixed priority: both request for 10 cycles, then m0 drops.
    f0_acc = 0; f1_acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      f0_if.read = H; f1_if.read = H;
      @(negedge clk);
      if (!f0_if.waitrequest) f0_acc++;
      if (!f1_if.waitrequest) f1_acc++;
    end
    check("fixed m0 accepts", f0_acc, 10);
    check("fixed m1 accepts", f1_acc, 0);
    @(posedge clk); #1;
    f0_if.read = L;
    @(negedge clk);
    check("fixed m1 after drop", f1_if.waitrequest, 0);
    @(posedge clk); #1;
    f1_if.read = L;

    // Reset asserted right after an m0 read accept.
    @(posedge clk); #1;
    set_m(H, L, L, L);
    @(negedge clk);
    check("rst m0 accept", m0_if.waitrequest, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    m0_if.read = L; m0_if.write = H; m0_if.address = 11'd2; m0_if.writedata = 32'h0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst no write", mem[2], 32'hA5A5_0002);
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_m(H, L, H, L);
    @(negedge clk);
    check("post rst tie wait0", m0_if.waitrequest, 0);
    check("post rst tie wait1", m1_if.waitrequest, 1);
    check("post rst rdv0", m0_if.readdatavalid, 0);
    @(posedge clk); #1;
    set_m(L, L, L, L);
    @(negedge clk);
    check("post rst rdv0 next", m0_if.readdatavalid, 1);
    check("post rst rdata", m0_if.readdata, X5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

- Shares the single-port 2048×32 on-chip RAM (`onchip_memory2_0`) between two Avalon-MM-style requesters: master 0 is the Nios data port and master 1 is the board-search engine.
- Arbitrates per access, round-robin by default, with an optional bounded lock for read-modify-write sequences.
- Routes the 1-cycle-latency RAM read data back to the requester that issued the read.
- Sits directly between the two masters and the RAM's s1 port.

## Interface
Parameters:
- `ADDR_W`, 11, word address width (matches RAM depth 2048)
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `FIXED_PRIO`, 0, 0 = round-robin; 1 = master 0 always wins ties
- `LOCK_MAX`, 16, maximum consecutive granted cycles under lock before forced release (2..255)

Ports:
- Clock and reset: single clock `clk`; reset `reset_n` is asynchronous and active-low.
  - `clk` in 1 system clock
  - `reset_n` in 1 asynchronous active-low reset
- Master ports, N = 0 and 1:
  - `mN_address` in ADDR_W word address
  - `mN_read` / `mN_write` in 1 each, request strobes (both high is illegal)
  - `mN_byteenable` in DATA_W/8 write byte lanes
  - `mN_writedata` in DATA_W write data
  - `mN_lock` in 1 hold the grant after this access
  - `mN_waitrequest` out 1 request not accepted this cycle
  - `mN_readdata` out DATA_W read data
  - `mN_readdatavalid` out 1 readdata valid
- RAM port:
  - `ram_address` out ADDR_W
  - `ram_byteenable` out DATA_W/8
  - `ram_chipselect` out 1
  - `ram_write` out 1
  - `ram_writedata` out DATA_W
  - `ram_clken` out 1, constant 1 after reset
  - `ram_readdata` in DATA_W

## Operation
- **Request and accept:** a master requests when `mN_read|mN_write`. An access is accepted in a cycle where the request is high and `mN_waitrequest` is low. At most one access is accepted per cycle.
- **RAM drive:** RAM outputs are a combinational mux of the granted master. `ram_chipselect` = accepted access this cycle. `ram_write` = accepted write.
- **Read return:** the id of an accepted read is registered. `mN_readdatavalid` goes high the next cycle for that id only. `ram_readdata` is fanned out to both `mN_readdata`.
- **FSM states:**
  - **ARB**
    - One requester: it is granted.
    - Both request: in round-robin the winner is the master other than `last_grant`; with `FIXED_PRIO` the winner is master 0.
    - `last_grant` updates on every accept.
    - Accepted access with `mN_lock=1`: go to LOCKN and clear `lock_cnt`.
  - **LOCKN**
    - Only master N can be granted; the other master's waitrequest is held high.
    - `lock_cnt` increments every cycle in LOCKN, including idle cycles.
    - Exit to ARB when:
      - an accepted access has `mN_lock=0`, or
      - `mN_lock=0` while master N is idle, or
      - `lock_cnt == LOCK_MAX-1`. This is a forced release; the access in that cycle is still served.
    - After a forced release, `last_grant=N`, so the other master wins the next tie.
- **Ordering:** accesses are strictly in order. A write followed by a read of the same address returns the new data; the RAM sees them in successive cycles.
- **Illegal `read&write`:** treated as a write.

## Timing
- Reset values:
  - `mN_readdatavalid=0`, `mN_waitrequest=1`, `ram_chipselect=0`, `ram_write=0`, `ram_clken=0`
  - `state=ARB`, `last_grant=1` (so master 0 wins the first tie), `lock_cnt=0`
- After deassertion the first accept is possible in the first clock edge.
- Read latency: accept edge + 1 cycle. Sustained throughput: 1 access per cycle, mixed masters, no bubbles.
- `mN_waitrequest` is combinational from the requests and registered state, with no dependency on `ram_readdata`.
- Reset asserted mid-operation: an in-flight readdatavalid is dropped, the lock is cleared, and no RAM write occurs while `reset_n=0`.
- A request withdrawn while waitrequest is high is legal and has no side effect.

## Structure
- Package `onchip_mem_arb_pkg`:
  - defaults for `ADDR_W` and `DATA_W`
  - state enum {ARB, LOCK0, LOCK1}
  - master-id type (1 bit)
- Sub-module `rr_arb2`: combinational 2-way pick.
  - Inputs: req[1:0], last_grant, fixed_prio.
  - Output: one-hot grant.
  - Reused by the FSM in ARB.

## Test plan
- **Tie, then alternation:** m0 and m1 read addr 5 / 6 together every cycle from reset → grants alternate m0, m1, m0…. Each readdatavalid arrives 1 cycle after its accept with the correct word. No cycle has two accepts.
- **Write-then-read:** m1 writes 0xDEADBEEF to addr 0x7FF with byteenable 4'b0011, then reads it back the next cycle → reads 0x????BEEF, with the upper bytes keeping the prior contents.
- **Lock held:** m0 with lock=1 for 3 accesses while m1 requests continuously → m1 waitrequest stays high until m0's access with lock=0 is accepted. m1 is then granted the next cycle.
- **Forced release:** m1 holds lock=1 and requests for 40 cycles while m0 waits, with `LOCK_MAX`=16 → m1 gets exactly 16 accepts. m0 is granted on cycle 17.
- **Fixed priority:** `FIXED_PRIO`=1 with both masters requesting for 10 cycles → all 10 accepts go to m0. m1 is granted the cycle m0 drops its request.
- **Reset mid-read:** `reset_n` is pulled low the cycle after an m0 read accept → `m0_readdatavalid` stays 0. After release, the outputs match the reset values and the first tie goes to m0.
